// File: rtl/mc_frame_source.sv
// mc_frame_source
//
// This block buffers one frame of N samples and replays it to the Monte-Carlo
// FFT->MULT->IFFT core. A loader fills the buffer through a valid/ready
// handshake. The block then drives the whole frame as a single gap-free
// in_valid burst. It does not accept another frame until the core has returned
// N out_valid cycles, or until a watchdog expires.
//
// Ports
//   clk            single clock; all logic is on the rising edge
//   rst_n          asynchronous active-low reset
//   ld_valid       loader sample valid
//   ld_ready       block accepts a sample this cycle (registered)
//   ld_x_real      loader x sample
//   ld_delta_real  loader delta real sample
//   ld_delta_img   loader delta imaginary sample
//   in_valid       burst valid toward the MC core (registered)
//   x_real         x sample toward the core, zero outside the burst
//   delta_real     delta real sample toward the core, zero outside the burst
//   delta_img      delta imaginary sample toward the core, zero outside the burst
//   mc_out_valid   out_valid returned by the MC core
//   frame_done     one-cycle pulse when a frame completes
//   frame_cnt      completed frames, wraps 0xFFFF -> 0x0000
//   err            sticky flags: [0] out_valid seen outside WAIT, [1] WAIT timeout

module mc_frame_source #(
    parameter int N       = 256,
    parameter int AW      = 8,
    parameter int DW      = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [DW-1:0] ld_x_real,
    input  logic [DW-1:0] ld_delta_real,
    input  logic [DW-1:0] ld_delta_img,
    output logic          in_valid,
    output logic [DW-1:0] x_real,
    output logic [DW-1:0] delta_real,
    output logic [DW-1:0] delta_img,
    input  logic          mc_out_valid,
    output logic          frame_done,
    output logic [15:0]   frame_cnt,
    output logic [1:0]    err
);

    // The watchdog counter must be able to hold TIMEOUT-1.
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] ret_cnt;
    logic [TW-1:0] tmo_cnt;

    // The frame buffer has no reset. Every entry is rewritten before it is read.
    logic [DW-1:0] mem_x  [N];
    logic [DW-1:0] mem_dr [N];
    logic [DW-1:0] mem_di [N];

    logic accept;     // sample handshake completes on this edge
    logic last_in;    // handshake for entry N-1
    logic last_out;   // entry N-1 is presented on this edge
    logic ret_hit;    // N-th returned out_valid arrives on this edge
    logic tmo_hit;    // watchdog expires on this edge (completion has priority)
    logic spurious;   // out_valid from the core while no frame is outstanding

    always_comb begin
        accept   = (state == LOAD) && ld_valid && ld_ready;
        last_in  = accept && (wr_ptr == AW'(N - 1));
        last_out = (state == SEND) && (rd_ptr == AW'(N - 1));
        ret_hit  = (state == WAIT) && mc_out_valid && (ret_cnt == AW'(N - 1));
        tmo_hit  = (state == WAIT) && !ret_hit && (tmo_cnt == TW'(TIMEOUT - 1));
        spurious = mc_out_valid && (state != WAIT);
    end

    always_comb begin
        state_nx = state;
        case (state)
            LOAD:    if (last_in)            state_nx = SEND;
            SEND:    if (last_out)           state_nx = WAIT;
            WAIT:    if (ret_hit || tmo_hit) state_nx = LOAD;
            default:                         state_nx = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD;
        end else begin
            state <= state_nx;
        end
    end

    // ld_ready is taken from the next state. It therefore rises one edge after
    // reset, falls on the edge that accepts entry N-1, and rises again on the
    // completion or timeout edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_ready   <= 1'b0;
            in_valid   <= 1'b0;
            x_real     <= '0;
            delta_real <= '0;
            delta_img  <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            ret_cnt    <= '0;
            tmo_cnt    <= '0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
            err        <= '0;
        end else begin
            ld_ready   <= (state_nx == LOAD);
            frame_done <= ret_hit;
            err        <= err | {tmo_hit, spurious};

            if (ret_hit) begin
                frame_cnt <= frame_cnt + 16'd1;
            end

            // N is a power of two, so the write pointer wraps back to 0
            // by itself after entry N-1.
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end

            // The burst is registered straight from the buffer. Outside SEND
            // the data registers load zeros, so the multiplier sees zeros
            // between bursts.
            if (state == SEND) begin
                in_valid   <= 1'b1;
                x_real     <= mem_x[rd_ptr];
                delta_real <= mem_dr[rd_ptr];
                delta_img  <= mem_di[rd_ptr];
                rd_ptr     <= rd_ptr + 1'b1;
            end else begin
                in_valid   <= 1'b0;
                x_real     <= '0;
                delta_real <= '0;
                delta_img  <= '0;
            end

            if (state == WAIT) begin
                if (ret_hit || tmo_hit) begin
                    ret_cnt <= '0;
                    tmo_cnt <= '0;
                end else begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (mc_out_valid) begin
                        ret_cnt <= ret_cnt + 1'b1;
                    end
                end
            end else begin
                ret_cnt <= '0;
                tmo_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem_x[wr_ptr]  <= ld_x_real;
            mem_dr[wr_ptr] <= ld_delta_real;
            mem_di[wr_ptr] <= ld_delta_img;
        end
    end

endmodule

// File: tb/tb_mc_frame_source.sv
// Directed testbench for mc_frame_source: frame load, burst replay, returns,
// timeout, spurious returns, asynchronous reset and frame counter wrap.

module tb_mc_frame_source;

    localparam int N       = 256;
    localparam int AW      = 8;
    localparam int DW      = 16;
    localparam int TIMEOUT = 4096;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ld_valid = 1'b0;
    logic          ld_ready;
    logic [DW-1:0] ld_x_real = '0;
    logic [DW-1:0] ld_delta_real = '0;
    logic [DW-1:0] ld_delta_img = '0;
    logic          in_valid;
    logic [DW-1:0] x_real;
    logic [DW-1:0] delta_real;
    logic [DW-1:0] delta_img;
    logic          mc_out_valid = 1'b0;
    logic          frame_done;
    logic [15:0]   frame_cnt;
    logic [1:0]    err;

    mc_frame_source #(
        .N       (N),
        .AW      (AW),
        .DW      (DW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ld_valid      (ld_valid),
        .ld_ready      (ld_ready),
        .ld_x_real     (ld_x_real),
        .ld_delta_real (ld_delta_real),
        .ld_delta_img  (ld_delta_img),
        .in_valid      (in_valid),
        .x_real        (x_real),
        .delta_real    (delta_real),
        .delta_img     (delta_img),
        .mc_out_valid  (mc_out_valid),
        .frame_done    (frame_done),
        .frame_cnt     (frame_cnt),
        .err           (err)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    logic [3*DW:0] cap [N+2];
    logic          rdy_seen;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, got hang expected $finish");
        $fatal(1);
    end

    // Per-frame sample pattern. Frame 0 is x=k, delta_real=2k, delta_img=-k.
    function automatic logic [DW-1:0] gx(input int fid, input int k);
        return DW'(k + fid * 1000);
    endfunction
    function automatic logic [DW-1:0] gdr(input int fid, input int k);
        return DW'(2 * k - fid);
    endfunction
    function automatic logic [DW-1:0] gdi(input int fid, input int k);
        return DW'(3 * fid - k);
    endfunction

    // Expected {in_valid, x, dr, di} at capture slot j. Slot 0 follows the
    // last-accept edge; slot j follows the j-th edge after it.
    function automatic logic [3*DW:0] expect_at(input int fid, input int j);
        if (j >= 1 && j <= N) return {1'b1, gx(fid, j - 1), gdr(fid, j - 1), gdi(fid, j - 1)};
        return '0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_frame(input int fid, input bit bp, output int accepted);
        int   k;
        int   cyc;
        logic r;
        k   = 0;
        cyc = 0;
        while (k < N && cyc < 8 * N) begin
            ld_valid = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (ld_valid) begin
                ld_x_real     = gx(fid, k);
                ld_delta_real = gdr(fid, k);
                ld_delta_img  = gdi(fid, k);
            end else begin
                ld_x_real     = 16'hBAD0;
                ld_delta_real = 16'hBAD1;
                ld_delta_img  = 16'hBAD2;
            end
            r = ld_ready;
            step();
            cyc++;
            if (ld_valid && r) k++;
        end
        ld_valid = 1'b0;
        accepted = k;
    endtask

    task automatic capture_burst(input bit ldv);
        rdy_seen = ld_ready;
        cap[0]   = {in_valid, x_real, delta_real, delta_img};
        for (int j = 1; j <= N + 1; j++) begin
            ld_valid      = ldv;
            ld_x_real     = 16'hDEAD;
            ld_delta_real = 16'hDEAD;
            ld_delta_img  = 16'hDEAD;
            step();
            cap[j]   = {in_valid, x_real, delta_real, delta_img};
            rdy_seen = rdy_seen | ld_ready;
        end
        ld_valid = 1'b0;
    endtask

    task automatic return_frame(input int n, input bit ldv, output int done_cnt, output int done_at);
        done_cnt = 0;
        done_at  = -1;
        for (int i = 0; i < n; i++) begin
            mc_out_valid = 1'b1;
            ld_valid     = ldv;
            step();
            if (frame_done === 1'b1) begin done_cnt++; done_at = i; end
        end
        mc_out_valid = 1'b0;
        ld_valid     = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            if (frame_done === 1'b1) begin done_cnt++; done_at = n + i; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        chk_cnt++;
        if ({ld_ready, in_valid, x_real, delta_real, delta_img, frame_done, frame_cnt, err} !== '0)
            $display("FAIL reset_values: got ld_ready=%b in_valid=%b x=%h dr=%h di=%h done=%b cnt=%h err=%b, expected all 0",
                     ld_ready, in_valid, x_real, delta_real, delta_img, frame_done, frame_cnt, err);
        else pass_cnt++;
        rst_n = 1'b1;
        chk_cnt++;
        if (ld_ready !== 1'b0) $display("FAIL ready_before_edge: got %b expected 0", ld_ready);
        else pass_cnt++;
        step();
        chk_cnt++;
        if (ld_ready !== 1'b1) $display("FAIL ready_first_edge: got %b expected 1", ld_ready);
        else pass_cnt++;
    endtask

    task automatic test_basic_frame();
        int acc, errs, first_j, dc, da;
        load_frame(0, 1'b0, acc);
        chk_cnt++;
        if (acc !== N) $display("FAIL basic_accepted: got %0d expected %0d", acc, N);
        else pass_cnt++;
        capture_burst(1'b0);
        errs = 0; first_j = 0;
        for (int j = 0; j < N + 2; j++)
            if (cap[j] !== expect_at(0, j)) begin if (errs == 0) first_j = j; errs++; end
        chk_cnt++;
        if (errs != 0) $display("FAIL basic_burst: %0d bad slots, slot %0d got %h expected %h",
                                errs, first_j, cap[first_j], expect_at(0, first_j));
        else pass_cnt++;
        chk_cnt++;
        if (rdy_seen !== 1'b0) $display("FAIL basic_ready_in_send: got %b expected 0", rdy_seen);
        else pass_cnt++;
        return_frame(N, 1'b0, dc, da);
        chk_cnt++;
        if (dc !== 1 || da !== N - 1) $display("FAIL basic_done: got count %0d at %0d expected 1 at %0d", dc, da, N - 1);
        else pass_cnt++;
        chk_cnt++;
        if ({frame_cnt, err, ld_ready} !== {16'd1, 2'b00, 1'b1})
            $display("FAIL basic_status: got cnt=%h err=%b rdy=%b expected cnt=0001 err=00 rdy=1", frame_cnt, err, ld_ready);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        int acc, errs, first_j, dc, da;
        load_frame(1, 1'b1, acc);
        chk_cnt++;
        if (acc !== N) $display("FAIL bp_accepted: got %0d expected %0d", acc, N);
        else pass_cnt++;
        capture_burst(1'b1);
        errs = 0; first_j = 0;
        for (int j = 0; j < N + 2; j++)
            if (cap[j] !== expect_at(1, j)) begin if (errs == 0) first_j = j; errs++; end
        chk_cnt++;
        if (errs != 0) $display("FAIL bp_burst: %0d bad slots, slot %0d got %h expected %h",
                                errs, first_j, cap[first_j], expect_at(1, first_j));
        else pass_cnt++;
        chk_cnt++;
        if (rdy_seen !== 1'b0) $display("FAIL bp_ready_in_send: got %b expected 0", rdy_seen);
        else pass_cnt++;
        return_frame(N, 1'b1, dc, da);
        chk_cnt++;
        if (dc !== 1 || frame_cnt !== 16'd2 || err !== 2'b00)
            $display("FAIL bp_done: got done=%0d cnt=%h err=%b expected done=1 cnt=0002 err=00", dc, frame_cnt, err);
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        int acc, errs, first_j, dc, da;
        logic early;
        load_frame(2, 1'b0, acc);
        capture_burst(1'b0);
        // Now one edge past WAIT entry.
        for (int i = 0; i < 100; i++) begin
            mc_out_valid = 1'b1;
            step();
        end
        mc_out_valid = 1'b0;
        early = 1'b0;
        for (int off = 102; off <= TIMEOUT - 1; off++) begin
            step();
            if (frame_done !== 1'b0 || ld_ready !== 1'b0) early = 1'b1;
        end
        chk_cnt++;
        if ({early, ld_ready, err} !== 4'b0000)
            $display("FAIL tmo_early: got early=%b rdy=%b err=%b expected 0 0 00", early, ld_ready, err);
        else pass_cnt++;
        step();
        chk_cnt++;
        if ({ld_ready, err, frame_done, frame_cnt} !== {1'b1, 2'b10, 1'b0, 16'd2})
            $display("FAIL tmo_fire: got rdy=%b err=%b done=%b cnt=%h expected 1 10 0 0002",
                     ld_ready, err, frame_done, frame_cnt);
        else pass_cnt++;
        step();
        chk_cnt++;
        if ({frame_done, frame_cnt} !== {1'b0, 16'd2})
            $display("FAIL tmo_after: got done=%b cnt=%h expected 0 0002", frame_done, frame_cnt);
        else pass_cnt++;
        load_frame(3, 1'b0, acc);
        capture_burst(1'b0);
        errs = 0; first_j = 0;
        for (int j = 0; j < N + 2; j++)
            if (cap[j] !== expect_at(3, j)) begin if (errs == 0) first_j = j; errs++; end
        chk_cnt++;
        if (errs != 0) $display("FAIL tmo_next_burst: %0d bad slots, slot %0d got %h expected %h",
                                errs, first_j, cap[first_j], expect_at(3, first_j));
        else pass_cnt++;
        return_frame(N, 1'b0, dc, da);
        chk_cnt++;
        if (dc !== 1 || frame_cnt !== 16'd3 || err !== 2'b10)
            $display("FAIL tmo_next_done: got done=%0d cnt=%h err=%b expected 1 0003 10", dc, frame_cnt, err);
        else pass_cnt++;
    endtask

    task automatic test_spurious_return();
        int acc, errs, first_j, dc, da;
        for (int i = 0; i < 3; i++) begin
            mc_out_valid = 1'b1;
            step();
        end
        mc_out_valid = 1'b0;
        chk_cnt++;
        if ({err, ld_ready, in_valid} !== {2'b11, 1'b1, 1'b0})
            $display("FAIL spur_load: got err=%b rdy=%b in_valid=%b expected 11 1 0", err, ld_ready, in_valid);
        else pass_cnt++;
        load_frame(4, 1'b0, acc);
        capture_burst(1'b0);
        errs = 0; first_j = 0;
        for (int j = 0; j < N + 2; j++)
            if (cap[j] !== expect_at(4, j)) begin if (errs == 0) first_j = j; errs++; end
        chk_cnt++;
        if (errs != 0) $display("FAIL spur_burst: %0d bad slots, slot %0d got %h expected %h",
                                errs, first_j, cap[first_j], expect_at(4, first_j));
        else pass_cnt++;
        return_frame(N, 1'b0, dc, da);
        chk_cnt++;
        if (dc !== 1 || frame_cnt !== 16'd4)
            $display("FAIL spur_done: got done=%0d cnt=%h expected 1 0004", dc, frame_cnt);
        else pass_cnt++;
        mc_out_valid = 1'b1;
        step();
        mc_out_valid = 1'b0;
        step();
        chk_cnt++;
        if ({frame_done, frame_cnt, err, ld_ready, in_valid} !== {1'b0, 16'd4, 2'b11, 1'b1, 1'b0})
            $display("FAIL spur_after: got done=%b cnt=%h err=%b rdy=%b iv=%b expected 0 0004 11 1 0",
                     frame_done, frame_cnt, err, ld_ready, in_valid);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_burst();
        int acc, errs, first_j, dc, da;
        load_frame(5, 1'b0, acc);
        for (int j = 1; j <= 101; j++) step();
        chk_cnt++;
        if ({in_valid, x_real} !== {1'b1, gx(5, 100)})
            $display("FAIL rst_entry100: got iv=%b x=%h expected 1 %h", in_valid, x_real, gx(5, 100));
        else pass_cnt++;
        #2;
        rst_n = 1'b0;
        #1;
        chk_cnt++;
        if ({in_valid, x_real, delta_real, delta_img, ld_ready, frame_cnt, err} !== '0)
            $display("FAIL rst_async: got iv=%b x=%h dr=%h di=%h rdy=%b cnt=%h err=%b expected all 0",
                     in_valid, x_real, delta_real, delta_img, ld_ready, frame_cnt, err);
        else pass_cnt++;
        step();
        step();
        rst_n = 1'b1;
        step();
        load_frame(6, 1'b0, acc);
        capture_burst(1'b0);
        errs = 0; first_j = 0;
        for (int j = 0; j < N + 2; j++)
            if (cap[j] !== expect_at(6, j)) begin if (errs == 0) first_j = j; errs++; end
        chk_cnt++;
        if (errs != 0) $display("FAIL rst_reload_burst: %0d bad slots, slot %0d got %h expected %h",
                                errs, first_j, cap[first_j], expect_at(6, first_j));
        else pass_cnt++;
        return_frame(N, 1'b0, dc, da);
        chk_cnt++;
        if (dc !== 1 || frame_cnt !== 16'd1 || err !== 2'b00)
            $display("FAIL rst_reload_done: got done=%0d cnt=%h err=%b expected 1 0001 00", dc, frame_cnt, err);
        else pass_cnt++;
    endtask

    task automatic test_counter_wrap();
        int acc, dc, da;
        force dut.frame_cnt = 16'hFFFF;
        step();
        release dut.frame_cnt;
        #1;
        if (frame_cnt === 16'hFFFF) begin
            load_frame(7, 1'b0, acc);
            capture_burst(1'b0);
            return_frame(N, 1'b0, dc, da);
            chk_cnt++;
            if (dc !== 1 || da !== N - 1 || frame_cnt !== 16'h0000)
                $display("FAIL wrap: got done=%0d at %0d cnt=%h expected 1 at %0d cnt=0000", dc, da, frame_cnt, N - 1);
            else pass_cnt++;
        end else begin
            $display("note: frame_cnt preload not retained after release; wrap check skipped");
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_timeout();
        test_spurious_return();
        test_reset_mid_burst();
        test_counter_wrap();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/mc_frame_source.md
# mc_frame_source

Frame source for the Monte-Carlo FFT→MULT→IFFT datapath. Accepts one frame of N samples (x_real, delta_real, delta_img) from an upstream loader through a valid/ready handshake and buffers it. It then replays the frame to the MC core as one contiguous in_valid burst. It holds off the next frame until the core has returned N out_valid cycles, with a watchdog and sticky error flags.

## Interface

- N, 256, samples per frame; power of two, ≥ 2.
- AW, 8, log2(N); width of buffer pointers.
- DW, 16, sample width (signed two's complement).
- TIMEOUT, 4096, maximum cycles spent in WAIT before abort.
- clk  in  1  single clock, all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ld_valid  in  1  loader sample valid.
- ld_ready  out  1  block accepts a sample this cycle; registered.
- ld_x_real  in  DW  loader x sample.
- ld_delta_real  in  DW  loader delta real sample.
- ld_delta_img  in  DW  loader delta imaginary sample.
- in_valid  out  1  burst valid toward the MC core; registered.
- x_real  out  DW  sample toward the MC core; registered.
- delta_real  out  DW  delta real sample toward the MC core; registered.
- delta_img  out  DW  delta imaginary sample toward the MC core; registered.
- mc_out_valid  in  1  out_valid returned by the MC core.
- frame_done  out  1  one-cycle pulse when a frame completes.
- frame_cnt  out  16  completed frames; wraps 0xFFFF→0x0000.
- err  out  2  sticky error flags. err[0] = mc_out_valid seen outside WAIT. err[1] = WAIT timeout.

## Operation

- Storage: three N×DW register arrays written at wr_ptr and read at rd_ptr. Array contents are not reset.
- FSM states and transitions:
  - LOAD: ld_ready=1. On each ld_valid&ld_ready, write all three samples at wr_ptr, then wr_ptr+1. On acceptance of sample N-1, go to SEND and set wr_ptr=0.
  - SEND: in_valid=1 for exactly N consecutive cycles, driving entries rd_ptr = 0..N-1 in order. After entry N-1 is presented, go to WAIT and set rd_ptr=0. ld_valid is ignored.
  - WAIT: ret_cnt counts cycles with mc_out_valid=1 and tmo_cnt counts every cycle. ld_valid is ignored.
    - If ret_cnt reaches N: pulse frame_done, increment frame_cnt, go to LOAD.
    - Else, if tmo_cnt reaches TIMEOUT: set err[1], go to LOAD with no frame_done and no frame_cnt increment.
    - Completion and timeout in the same cycle: completion wins.
- Zero-drive: x_real, delta_real and delta_img are 0 whenever in_valid=0. The MC multiplier must see zeros outside the burst.
- err[0] is set on any cycle with mc_out_valid=1 while in LOAD or SEND. This includes extra out_valid cycles after completion. It does not change state.
- err bits clear only on reset. An error does not block later frames.
- Pointers and counters are AW bits wide and wrap naturally. No full or empty flags are exported: the buffer is full exactly on leaving LOAD.

## Timing

- Reset values, asserted asynchronously: state=LOAD, ld_ready=0, in_valid=0, x_real/delta_real/delta_img=0, frame_done=0, frame_cnt=0, err=0, all pointers and counters 0.
- ld_ready rises on the first rising edge after rst_n deasserts.
- ld_ready falls on the same edge that accepts sample N-1, so it is never high in SEND or WAIT.
- Load-to-burst latency: if sample N-1 is accepted at edge t, in_valid=1 with entry 0 is visible after edge t+1.
- Entry k is visible after edge t+1+k. in_valid falls after edge t+1+N.
- There are no gaps inside the burst.
- frame_done is high for the one cycle after the edge where ret_cnt hits N. ld_ready rises at that same edge.
- Reset mid-operation (any state) aborts immediately. No partial burst resumes; the next frame must be fully reloaded.
- Loader stalls (ld_valid=0) in LOAD are permitted indefinitely. There is no timeout in LOAD.

## Test plan

- Basic frame: after reset, load N samples with x=k, delta_real=2k, delta_img=-k. The burst must be exactly 256 contiguous in_valid cycles carrying k in order. Drive 256 mc_out_valid cycles; then frame_done pulses once, frame_cnt=1, err=0.
- Loader backpressure: ld_valid toggles randomly during load, plus ld_valid=1 during SEND and WAIT. Only N samples are accepted, with none dropped or duplicated. The burst begins exactly 1 cycle after the last acceptance, and outputs are 0 outside the burst.
- Timeout: after the burst, drive only 100 mc_out_valid cycles. After TIMEOUT=4096 cycles in WAIT: err=2'b10, no frame_done, frame_cnt unchanged, ld_ready=1. The next full frame completes normally.
- Spurious return: assert mc_out_valid for 3 cycles during LOAD and 1 cycle after completion. Then err[0]=1 and the FSM is unaffected; the following frame completes with frame_cnt incremented.
- Reset mid-burst: assert rst_n=0 at burst entry 100. Outputs go to 0 asynchronously and in_valid falls without waiting for a clock. After release, a fresh 256-sample load yields a complete, correct burst.
- Counter wrap: preload or run 65536 frames with a short TIMEOUT. frame_cnt goes 0xFFFF→0x0000 and frame_done still pulses.
